// File: rtl/atmega_uart_pkg.sv
// Shared definitions for the ATmega UART transmit feeder: UCSRA bit positions and feeder FSM states.
package atmega_uart_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned UCSRA_UDRE = 5;
    localparam int unsigned UCSRA_TXC  = 6;
    localparam int unsigned UCSRA_RXC  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POLL  = 2'd1,
        WRITE = 2'd2,
        GAP   = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/atmega_uart_tx_feeder_if.sv
// Producer push port, I/O-bus master port and FIFO status of the UART transmit feeder.
// Optional build macro: TX_FEEDER_LEVEL_EN adds the level signal.
interface atmega_uart_tx_feeder_if #(
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned BUS_ADDR_IO_LEN = 16
);
    logic [7:0]                 push_data;
    logic                       push_valid;
    logic                       push_ready;
    logic                       bus_req;
    logic                       bus_gnt;
    logic [BUS_ADDR_IO_LEN-1:0] addr_io;
    logic                       rd_io;
    logic                       wr_io;
    logic [7:0]                 bus_io_out;
    logic [7:0]                 bus_io_in;
    logic                       empty;
`ifdef TX_FEEDER_LEVEL_EN
    logic [$clog2(DEPTH):0]     level;

    modport master (
        input  push_data, push_valid, bus_gnt, bus_io_in,
        output push_ready, bus_req, addr_io, rd_io, wr_io, bus_io_out, empty, level
    );
    modport slave (
        output push_data, push_valid, bus_gnt, bus_io_in,
        input  push_ready, bus_req, addr_io, rd_io, wr_io, bus_io_out, empty, level
    );
`else
    modport master (
        input  push_data, push_valid, bus_gnt, bus_io_in,
        output push_ready, bus_req, addr_io, rd_io, wr_io, bus_io_out, empty
    );
    modport slave (
        output push_data, push_valid, bus_gnt, bus_io_in,
        input  push_ready, bus_req, addr_io, rd_io, wr_io, bus_io_out, empty
    );
`endif

endinterface

// File: rtl/atmega_fifo_sync.sv
// Synchronous byte FIFO with wrap-bit pointers; TX_FEEDER_LEVEL_EN adds a registered occupancy output.
module atmega_fifo_sync
    import atmega_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [BYTE_W-1:0]      din,
    output logic [BYTE_W-1:0]      head,
    output logic                   full,
    output logic                   empty
`ifdef TX_FEEDER_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr_nx;
    logic [PW-1:0]     rd_ptr_nx;
    logic [BYTE_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    // Same slot with opposite wrap bits means every entry is occupied.
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign wr_ptr_nx = do_push ? wr_ptr + PW'(1) : wr_ptr;
    assign rd_ptr_nx = do_pop  ? rd_ptr + PW'(1) : rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
        end
    end

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

`ifdef TX_FEEDER_LEVEL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else begin
            level <= PW'(wr_ptr_nx - rd_ptr_nx);
        end
    end
`endif

endmodule

// File: rtl/atmega_uart_tx_feeder.sv
// Buffered UART transmit feeder: queues producer bytes and writes them to UDR whenever UCSRA.UDRE is set.
// Optional build macro: TX_FEEDER_LEVEL_EN exposes the FIFO occupancy on the level signal.
module atmega_uart_tx_feeder
    import atmega_uart_pkg::*;
#(
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned BUS_ADDR_IO_LEN = 16,
    parameter int unsigned UDR_ADDR        = 'h0c,
    parameter int unsigned UCSRA_ADDR      = 'h0b
) (
    input  logic                          clk,
    input  logic                          rst,
    atmega_uart_tx_feeder_if.master       bus
);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("atmega_uart_tx_feeder: DEPTH must be a power of two in 2..256");
    end
    if (UDR_ADDR == 0 || UDR_ADDR >= 'h40 || UCSRA_ADDR == 0 || UCSRA_ADDR >= 'h40) begin : g_bad_addr
        $error("atmega_uart_tx_feeder: UART register addresses must be non-zero and below 'h40");
    end

    feeder_state_e     state;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [BYTE_W-1:0] head;
    logic              udre;

    atmega_fifo_sync #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.push_valid),
        .pop   (pop),
        .din   (bus.push_data),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
`ifdef TX_FEEDER_LEVEL_EN
        ,
        .level (bus.level)
`endif
    );

    assign bus.push_ready = ~fifo_full;
    assign bus.empty      = fifo_empty;
    assign udre           = bus.bus_io_in[UCSRA_UDRE];

    // GAP absorbs the cycle before UDRE drops after a UDR write, so no byte is written twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (!fifo_empty)           state <= POLL;
                POLL:    if (bus.bus_gnt && udre)   state <= WRITE;
                WRITE:   if (bus.bus_gnt)           state <= GAP;
                GAP:                                state <= IDLE;
                default:                            state <= IDLE;
            endcase
        end
    end

    // Strobes follow the live grant so a withdrawn grant never yields a partial access.
    always_comb begin
        bus.bus_req    = 1'b0;
        bus.rd_io      = 1'b0;
        bus.wr_io      = 1'b0;
        bus.addr_io    = '0;
        bus.bus_io_out = '0;
        pop            = 1'b0;
        unique case (state)
            POLL: begin
                bus.bus_req = 1'b1;
                bus.addr_io = BUS_ADDR_IO_LEN'(UCSRA_ADDR);
                bus.rd_io   = bus.bus_gnt;
            end
            WRITE: begin
                bus.bus_req    = 1'b1;
                bus.addr_io    = BUS_ADDR_IO_LEN'(UDR_ADDR);
                bus.bus_io_out = head;
                bus.wr_io      = bus.bus_gnt;
                pop            = bus.bus_gnt;
            end
            default: ;
        endcase
    end

endmodule
